// File: rtl/rvh_ptw_walk_responder.sv
// Memory-side responder for the PTW walk port. It queues walk requests in a
// small FIFO, performs one aligned 64-bit PTE read at a time and returns the
// PTEs in request order. A bus error comes back as an all-zero PTE (V=0) and
// bumps a saturating error counter.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no walk in progress; pops the FIFO head when one is queued
// MEM_REQ  | memory read request presented, waiting for mem_req_rdy_i
// MEM_WAIT | request accepted, waiting for read data (or error)
// RESP     | PTE presented to the PTW, waiting for ptw_walk_resp_rdy_i
`timescale 1ns/1ps
module rvh_ptw_walk_responder #(
    parameter int PTW_ID_WIDTH  = 1,
    parameter int PADDR_WIDTH   = 56,
    parameter int REQ_DEPTH     = 2,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     ptw_walk_req_vld_i,
    input  logic [PTW_ID_WIDTH-1:0]  ptw_walk_req_id_i,
    input  logic [PADDR_WIDTH-1:0]   ptw_walk_req_addr_i,
    output logic                     ptw_walk_req_rdy_o,
    output logic                     ptw_walk_resp_vld_o,
    output logic [PTW_ID_WIDTH-1:0]  ptw_walk_resp_id_o,
    output logic [63:0]              ptw_walk_resp_pte_o,
    input  logic                     ptw_walk_resp_rdy_i,
    output logic                     mem_req_vld_o,
    output logic [PADDR_WIDTH-1:0]   mem_req_addr_o,
    input  logic                     mem_req_rdy_i,
    input  logic                     mem_resp_vld_i,
    input  logic [63:0]              mem_resp_data_i,
    input  logic                     mem_resp_err_i,
    output logic                     mem_resp_rdy_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    localparam int AW = $clog2(REQ_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PADDR_WIDTH-1:0] ADDR_MASK = ~PADDR_WIDTH'(7);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [PTW_ID_WIDTH-1:0]  fifo_id_q   [REQ_DEPTH];
    logic [PADDR_WIDTH-1:0]   fifo_addr_q [REQ_DEPTH];
    logic                     full, empty, push, pop;

    logic [PTW_ID_WIDTH-1:0]  cur_id_q;
    logic [PADDR_WIDTH-1:0]   cur_addr_q;
    logic [63:0]              pte_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
    logic                     mem_resp_take;

    // Wrap-bit full/empty: same index, differing wrap bit means full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = ptw_walk_req_vld_i && !full;
    assign mem_resp_take = (state_q == MEM_WAIT) && mem_resp_vld_i;

    // Next-state logic; the FIFO is only popped when leaving IDLE.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ:  if (mem_req_rdy_i)       state_d = MEM_WAIT;
            MEM_WAIT: if (mem_resp_vld_i)      state_d = RESP;
            RESP:     if (ptw_walk_resp_rdy_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State, pointers, current walk and error counter.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cur_id_q   <= '0;
            cur_addr_q <= '0;
            pte_q      <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PW'(1);
                cur_id_q   <= fifo_id_q[rd_ptr_q[AW-1:0]];
                cur_addr_q <= fifo_addr_q[rd_ptr_q[AW-1:0]];
            end
            if (mem_resp_take) begin
                pte_q <= mem_resp_err_i ? 64'h0 : mem_resp_data_i;
                if (mem_resp_err_i && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}}))
                    err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
            end
        end
    end

    // FIFO storage needs no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_id_q[wr_ptr_q[AW-1:0]]   <= ptw_walk_req_id_i;
            fifo_addr_q[wr_ptr_q[AW-1:0]] <= ptw_walk_req_addr_i;
        end
    end

    assign ptw_walk_req_rdy_o  = !full;
    assign ptw_walk_resp_vld_o = (state_q == RESP);
    assign ptw_walk_resp_id_o  = cur_id_q;
    assign ptw_walk_resp_pte_o = pte_q;
    assign mem_req_vld_o       = (state_q == MEM_REQ);
    assign mem_req_addr_o      = cur_addr_q & ADDR_MASK;
    assign mem_resp_rdy_o      = (state_q == MEM_WAIT);
    assign err_cnt_o           = err_cnt_q;

endmodule

// File: tb/tb_rvh_ptw_walk_responder.sv
// Directed bench for rvh_ptw_walk_responder (ERR_CNT_WIDTH=2 so that
// saturation is reachable in a few errors).
`timescale 1ns/1ps
module tb_rvh_ptw_walk_responder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ptw_walk_req_vld_i;
    logic [0:0]  ptw_walk_req_id_i;
    logic [55:0] ptw_walk_req_addr_i;
    logic        ptw_walk_req_rdy_o;
    logic        ptw_walk_resp_vld_o;
    logic [0:0]  ptw_walk_resp_id_o;
    logic [63:0] ptw_walk_resp_pte_o;
    logic        ptw_walk_resp_rdy_i;
    logic        mem_req_vld_o;
    logic [55:0] mem_req_addr_o;
    logic        mem_req_rdy_i;
    logic        mem_resp_vld_i;
    logic [63:0] mem_resp_data_i;
    logic        mem_resp_err_i;
    logic        mem_resp_rdy_o;
    logic [1:0]  err_cnt_o;

    int n_vec = 0;
    int n_err = 0;
    bit mem_auto = 1'b0;
    bit mem_err_mode = 1'b0;

    rvh_ptw_walk_responder #(
        .PTW_ID_WIDTH(1), .PADDR_WIDTH(56), .REQ_DEPTH(2), .ERR_CNT_WIDTH(2)
    ) dut (
        .clk(clk), .rstn(rstn),
        .ptw_walk_req_vld_i(ptw_walk_req_vld_i), .ptw_walk_req_id_i(ptw_walk_req_id_i),
        .ptw_walk_req_addr_i(ptw_walk_req_addr_i), .ptw_walk_req_rdy_o(ptw_walk_req_rdy_o),
        .ptw_walk_resp_vld_o(ptw_walk_resp_vld_o), .ptw_walk_resp_id_o(ptw_walk_resp_id_o),
        .ptw_walk_resp_pte_o(ptw_walk_resp_pte_o), .ptw_walk_resp_rdy_i(ptw_walk_resp_rdy_i),
        .mem_req_vld_o(mem_req_vld_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_rdy_i(mem_req_rdy_i), .mem_resp_vld_i(mem_resp_vld_i),
        .mem_resp_data_i(mem_resp_data_i), .mem_resp_err_i(mem_resp_err_i),
        .mem_resp_rdy_o(mem_resp_rdy_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pte_of(input logic [55:0] a);
        return {8'h5A, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers one cycle after the request handshake.
    initial begin : mem_model
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto) begin
                if (mem_resp_vld_i) begin
                    mem_resp_vld_i  = 1'b0;
                    mem_resp_err_i  = 1'b0;
                    mem_resp_data_i = 64'h0;
                end else if (mem_resp_rdy_o) begin
                    mem_resp_vld_i  = 1'b1;
                    mem_resp_err_i  = mem_err_mode;
                    mem_resp_data_i = mem_err_mode ? 64'hFFFF_FFFF_FFFF_FFFF : pte_of(mem_req_addr_o);
                end
            end
        end
    end

    task automatic push(input logic [0:0] id, input logic [55:0] a);
        ptw_walk_req_vld_i  = 1'b1;
        ptw_walk_req_id_i   = id;
        ptw_walk_req_addr_i = a;
        for (int k = 0; k < 50 && !ptw_walk_req_rdy_o; k++) tick();
        if (!ptw_walk_req_rdy_o) begin
            n_vec++; n_err++;
            $display("FAIL push_timeout req_rdy got=%0b required=1", ptw_walk_req_rdy_o);
        end
        tick();
        ptw_walk_req_vld_i = 1'b0;
    endtask

    task automatic wait_resp();
        for (int k = 0; k < 50 && !ptw_walk_resp_vld_o; k++) tick();
        if (!ptw_walk_resp_vld_o) begin
            n_vec++; n_err++;
            $display("FAIL resp_timeout resp_vld got=%0b required=1", ptw_walk_resp_vld_o);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        ptw_walk_req_vld_i = 1'b0; ptw_walk_req_id_i = '0; ptw_walk_req_addr_i = '0;
        ptw_walk_resp_rdy_i = 1'b1; mem_req_rdy_i = 1'b1;
        mem_resp_vld_i = 1'b0; mem_resp_data_i = '0; mem_resp_err_i = 1'b0;
        tick(); tick();
        rstn = 1'b0;
        n_vec++; if (ptw_walk_req_rdy_o !== 1'b1) begin n_err++; $display("FAIL reset_req_rdy got=%0b required=1", ptw_walk_req_rdy_o); end
        n_vec++; if (ptw_walk_resp_vld_o !== 1'b0) begin n_err++; $display("FAIL reset_resp_vld got=%0b required=0", ptw_walk_resp_vld_o); end
        n_vec++; if (ptw_walk_resp_id_o !== 1'b0) begin n_err++; $display("FAIL reset_resp_id got=%0h required=0", ptw_walk_resp_id_o); end
        n_vec++; if (ptw_walk_resp_pte_o !== 64'h0) begin n_err++; $display("FAIL reset_resp_pte got=%0h required=0", ptw_walk_resp_pte_o); end
        n_vec++; if (mem_req_vld_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_vld got=%0b required=0", mem_req_vld_o); end
        n_vec++; if (mem_req_addr_o !== 56'h0) begin n_err++; $display("FAIL reset_mem_req_addr got=%0h required=0", mem_req_addr_o); end
        n_vec++; if (mem_resp_rdy_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_resp_rdy got=%0b required=0", mem_resp_rdy_o); end
        n_vec++; if (err_cnt_o !== 2'd0) begin n_err++; $display("FAIL reset_err_cnt got=%0d required=0", err_cnt_o); end
    endtask

    task automatic test_single_walk();
        mem_auto = 1'b0;
        push(1'b1, 56'h8000_1008);                       // now T+1
        n_vec++; if (mem_req_vld_o !== 1'b0) begin n_err++; $display("FAIL single_t1_mem_vld got=%0b required=0", mem_req_vld_o); end
        tick();                                          // T+2
        n_vec++; if (mem_req_vld_o !== 1'b1) begin n_err++; $display("FAIL single_t2_mem_vld got=%0b required=1", mem_req_vld_o); end
        n_vec++; if (mem_req_addr_o !== 56'h8000_1008) begin n_err++; $display("FAIL single_t2_addr got=%0h required=80001008", mem_req_addr_o); end
        tick();                                          // T+3
        n_vec++; if (mem_resp_rdy_o !== 1'b1 || ptw_walk_resp_vld_o !== 1'b0) begin n_err++; $display("FAIL single_t3 mem_resp_rdy=%0b resp_vld=%0b required 1,0", mem_resp_rdy_o, ptw_walk_resp_vld_o); end
        mem_resp_vld_i = 1'b1; mem_resp_data_i = 64'h0000_0000_2000_00CF; mem_resp_err_i = 1'b0;
        tick();                                          // T+4
        mem_resp_vld_i = 1'b0; mem_resp_data_i = '0;
        n_vec++; if (ptw_walk_resp_vld_o !== 1'b1) begin n_err++; $display("FAIL single_t4_resp_vld got=%0b required=1", ptw_walk_resp_vld_o); end
        n_vec++; if (ptw_walk_resp_pte_o !== 64'h2000_00CF) begin n_err++; $display("FAIL single_t4_pte got=%0h required=200000cf", ptw_walk_resp_pte_o); end
        n_vec++; if (ptw_walk_resp_id_o !== 1'b1) begin n_err++; $display("FAIL single_t4_id got=%0h required=1", ptw_walk_resp_id_o); end
        tick();
        n_vec++; if (ptw_walk_resp_vld_o !== 1'b0) begin n_err++; $display("FAIL single_after_resp_vld got=%0b required=0", ptw_walk_resp_vld_o); end
    endtask

    task automatic test_misaligned();
        mem_auto = 1'b1;
        push(1'b0, 56'h8000_100D);
        tick();
        n_vec++; if (mem_req_addr_o !== 56'h8000_1008) begin n_err++; $display("FAIL misaligned_addr got=%0h required=80001008", mem_req_addr_o); end
        wait_resp();
        n_vec++; if (ptw_walk_resp_pte_o !== pte_of(56'h8000_1008)) begin n_err++; $display("FAIL misaligned_pte got=%0h required=%0h", ptw_walk_resp_pte_o, pte_of(56'h8000_1008)); end
        tick();
    endtask

    task automatic test_mem_stall();
        logic [55:0] exp_a [3];
        logic [0:0]  exp_i [3];
        int got;
        exp_a[0] = 56'h4000; exp_a[1] = 56'h4010; exp_a[2] = 56'h4020;
        exp_i[0] = 1'b1;     exp_i[1] = 1'b0;     exp_i[2] = 1'b1;
        mem_auto = 1'b0;
        mem_req_rdy_i = 1'b0;
        for (int j = 0; j < 3; j++) push(exp_i[j], exp_a[j]);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin mem_resp_vld_i = 1'b1; mem_resp_err_i = 1'b1; mem_resp_data_i = 64'hFFFF_FFFF_FFFF_FFFF; end
            if (i == 2) begin mem_resp_vld_i = 1'b0; mem_resp_err_i = 1'b0; mem_resp_data_i = '0; end
            n_vec++; if (mem_req_vld_o !== 1'b1 || mem_req_addr_o !== 56'h4000) begin n_err++; $display("FAIL stall_mem_req cyc%0d vld=%0b addr=%0h required 1,4000", i, mem_req_vld_o, mem_req_addr_o); end
            n_vec++; if (ptw_walk_req_rdy_o !== 1'b0) begin n_err++; $display("FAIL stall_no_pop cyc%0d req_rdy=%0b required=0", i, ptw_walk_req_rdy_o); end
            tick();
        end
        n_vec++; if (err_cnt_o !== 2'd0 || mem_req_vld_o !== 1'b1) begin n_err++; $display("FAIL stray_resp err_cnt=%0d mem_req_vld=%0b required 0,1", err_cnt_o, mem_req_vld_o); end
        mem_auto = 1'b1;
        mem_req_rdy_i = 1'b1;
        got = 0;
        for (int k = 0; k < 60 && got < 3; k++) begin
            if (ptw_walk_resp_vld_o) begin
                n_vec++;
                if (ptw_walk_resp_id_o !== exp_i[got] || ptw_walk_resp_pte_o !== pte_of(exp_a[got])) begin
                    n_err++; $display("FAIL stall_order resp%0d id=%0h pte=%0h required %0h,%0h", got, ptw_walk_resp_id_o, ptw_walk_resp_pte_o, exp_i[got], pte_of(exp_a[got]));
                end
                got++;
            end
            tick();
        end
        n_vec++; if (got != 3) begin n_err++; $display("FAIL stall_drain responses=%0d required=3", got); end
    endtask

    task automatic test_backpressure();
        logic [55:0] exp_a [4];
        logic [0:0]  exp_i [4];
        int got;
        bit d_go;
        exp_a[0] = 56'h1000; exp_a[1] = 56'h2000; exp_a[2] = 56'h3000; exp_a[3] = 56'h5000;
        exp_i[0] = 1'b0;     exp_i[1] = 1'b1;     exp_i[2] = 1'b0;     exp_i[3] = 1'b1;
        mem_auto = 1'b1;
        ptw_walk_resp_rdy_i = 1'b0;
        push(exp_i[0], exp_a[0]);
        wait_resp();
        push(exp_i[1], exp_a[1]);
        push(exp_i[2], exp_a[2]);
        ptw_walk_req_vld_i = 1'b1; ptw_walk_req_id_i = exp_i[3]; ptw_walk_req_addr_i = exp_a[3];
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (ptw_walk_req_rdy_o !== 1'b0) begin n_err++; $display("FAIL bp_full cyc%0d req_rdy=%0b required=0", i, ptw_walk_req_rdy_o); end
            n_vec++; if (ptw_walk_resp_vld_o !== 1'b1 || ptw_walk_resp_id_o !== 1'b0 || ptw_walk_resp_pte_o !== pte_of(exp_a[0])) begin
                n_err++; $display("FAIL bp_hold cyc%0d vld=%0b id=%0h pte=%0h required 1,0,%0h", i, ptw_walk_resp_vld_o, ptw_walk_resp_id_o, ptw_walk_resp_pte_o, pte_of(exp_a[0]));
            end
            tick();
        end
        ptw_walk_resp_rdy_i = 1'b1;
        got = 0;
        for (int k = 0; k < 80 && got < 4; k++) begin
            d_go = ptw_walk_req_vld_i && ptw_walk_req_rdy_o;
            if (ptw_walk_resp_vld_o) begin
                n_vec++;
                if (ptw_walk_resp_id_o !== exp_i[got] || ptw_walk_resp_pte_o !== pte_of(exp_a[got])) begin
                    n_err++; $display("FAIL bp_order resp%0d id=%0h pte=%0h required %0h,%0h", got, ptw_walk_resp_id_o, ptw_walk_resp_pte_o, exp_i[got], pte_of(exp_a[got]));
                end
                got++;
            end
            tick();
            if (d_go) ptw_walk_req_vld_i = 1'b0;
        end
        ptw_walk_req_vld_i = 1'b0;
        n_vec++; if (got != 4) begin n_err++; $display("FAIL bp_drain responses=%0d required=4", got); end
    endtask

    task automatic test_mem_error();
        logic [1:0] exp_cnt;
        mem_auto = 1'b1;
        mem_err_mode = 1'b1;
        n_vec++; if (err_cnt_o !== 2'd0) begin n_err++; $display("FAIL err_cnt_start got=%0d required=0", err_cnt_o); end
        for (int e = 0; e < 5; e++) begin
            exp_cnt = (e >= 2) ? 2'd3 : 2'(e + 1);
            push(1'b1, 56'h6000 + 56'(e * 8));
            wait_resp();
            n_vec++; if (ptw_walk_resp_pte_o !== 64'h0) begin n_err++; $display("FAIL err_pte err%0d got=%0h required=0", e, ptw_walk_resp_pte_o); end
            n_vec++; if (err_cnt_o !== exp_cnt) begin n_err++; $display("FAIL err_cnt err%0d got=%0d required=%0d", e, err_cnt_o, exp_cnt); end
            tick();
        end
        mem_err_mode = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem_auto = 1'b0;
        mem_req_rdy_i = 1'b1;
        push(1'b0, 56'h7000);
        push(1'b1, 56'h7008);
        push(1'b0, 56'h7010);
        n_vec++; if (mem_resp_rdy_o !== 1'b1 || ptw_walk_req_rdy_o !== 1'b0) begin n_err++; $display("FAIL mid_setup mem_resp_rdy=%0b req_rdy=%0b required 1,0", mem_resp_rdy_o, ptw_walk_req_rdy_o); end
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        n_vec++; if (ptw_walk_req_rdy_o !== 1'b1) begin n_err++; $display("FAIL mid_req_rdy got=%0b required=1", ptw_walk_req_rdy_o); end
        n_vec++; if (ptw_walk_resp_vld_o !== 1'b0 || ptw_walk_resp_id_o !== 1'b0 || ptw_walk_resp_pte_o !== 64'h0) begin n_err++; $display("FAIL mid_resp vld=%0b id=%0h pte=%0h required 0,0,0", ptw_walk_resp_vld_o, ptw_walk_resp_id_o, ptw_walk_resp_pte_o); end
        n_vec++; if (mem_req_vld_o !== 1'b0 || mem_req_addr_o !== 56'h0 || mem_resp_rdy_o !== 1'b0) begin n_err++; $display("FAIL mid_mem req_vld=%0b addr=%0h resp_rdy=%0b required 0,0,0", mem_req_vld_o, mem_req_addr_o, mem_resp_rdy_o); end
        n_vec++; if (err_cnt_o !== 2'd0) begin n_err++; $display("FAIL mid_err_cnt got=%0d required=0", err_cnt_o); end
        tick();
        n_vec++; if (mem_req_vld_o !== 1'b0 || ptw_walk_req_rdy_o !== 1'b1) begin n_err++; $display("FAIL mid_fifo_empty mem_req_vld=%0b req_rdy=%0b required 0,1", mem_req_vld_o, ptw_walk_req_rdy_o); end
        mem_auto = 1'b1;
        push(1'b1, 56'h7100);
        wait_resp();
        n_vec++; if (ptw_walk_resp_id_o !== 1'b1 || ptw_walk_resp_pte_o !== pte_of(56'h7100)) begin n_err++; $display("FAIL mid_recover id=%0h pte=%0h required 1,%0h", ptw_walk_resp_id_o, ptw_walk_resp_pte_o, pte_of(56'h7100)); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_walk();
        test_misaligned();
        test_mem_stall();
        test_backpressure();
        test_mem_error();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
